// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage
// Sits directly behind the 16-bit add/sub ALU. Each accepted ALU result is
// buffered with its destination register in a small in-order queue, the
// architectural N/Z flags are updated at accept time, and the queue drains
// into the register-file write port under a valid/ready handshake. A
// combinational lookup lets the operand stage bypass buffered results.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   i_valid / o_ready   upstream handshake (o_ready depends on state only)
//   i_result, i_n, i_z  ALU result and flags
//   i_rd, i_wr_en       destination register and write enable
//   i_set_flags         instruction updates the N/Z flag register
//   o_rf_we, o_rf_waddr, o_rf_wdata, i_rf_ready   register-file write port
//   o_flag_n, o_flag_z  architectural flags
//   i_q_addr, o_fwd_hit, o_fwd_data   forwarding lookup
//   o_count             queue occupancy
module alu_writeback_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [DATA_W-1:0]        i_result,
  input  logic                     i_n,
  input  logic                     i_z,
  input  logic [ADDR_W-1:0]        i_rd,
  input  logic                     i_wr_en,
  input  logic                     i_set_flags,
  output logic                     o_rf_we,
  output logic [ADDR_W-1:0]        o_rf_waddr,
  output logic [DATA_W-1:0]        o_rf_wdata,
  input  logic                     i_rf_ready,
  output logic                     o_flag_n,
  output logic                     o_flag_z,
  input  logic [ADDR_W-1:0]        i_q_addr,
  output logic                     o_fwd_hit,
  output logic [DATA_W-1:0]        o_fwd_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] result_q [DEPTH];
  logic [DATA_W-1:0] result_d [DEPTH];
  logic [ADDR_W-1:0] rd_q     [DEPTH];
  logic [ADDR_W-1:0] rd_d     [DEPTH];
  logic [DEPTH-1:0]  wen_q, wen_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              flag_n_q, flag_n_d;
  logic              flag_z_q, flag_z_d;
  logic [ADDR_W-1:0] last_waddr_q, last_waddr_d;
  logic [DATA_W-1:0] last_wdata_q, last_wdata_d;

  logic accept;
  logic head_valid;
  logic head_wen;
  logic retire;

  // Ready comes only from the occupancy register, so a full queue stays
  // not-ready even in a cycle where the head retires.
  assign o_ready    = (count_q < CNT_W'(DEPTH));
  assign accept     = i_valid && o_ready;
  assign head_valid = (count_q != '0);
  assign head_wen   = wen_q[head_q];
  // Non-writing entries retire without waiting for the register file.
  assign retire     = head_valid && (!head_wen || i_rf_ready);

  assign o_rf_we    = head_valid && head_wen;
  // When no write is presented the port keeps showing the last write.
  assign o_rf_waddr = o_rf_we ? rd_q[head_q]     : last_waddr_q;
  assign o_rf_wdata = o_rf_we ? result_q[head_q] : last_wdata_q;

  assign o_flag_n = flag_n_q;
  assign o_flag_z = flag_z_q;
  assign o_count  = count_q;

  always_comb begin
    result_d     = result_q;
    rd_d         = rd_q;
    wen_d        = wen_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    flag_n_d     = flag_n_q;
    flag_z_d     = flag_z_q;
    last_waddr_d = last_waddr_q;
    last_wdata_d = last_wdata_q;

    if (accept) begin
      result_d[tail_q] = i_result;
      rd_d[tail_q]     = i_rd;
      wen_d[tail_q]    = i_wr_en;
      tail_d           = tail_q + PTR_W'(1);
      // Flags follow program order at accept time, independent of drain.
      if (i_set_flags) begin
        flag_n_d = i_n;
        flag_z_d = i_z;
      end
    end

    if (retire) begin
      head_d = head_q + PTR_W'(1);
    end

    case ({accept, retire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (o_rf_we) begin
      last_waddr_d = rd_q[head_q];
      last_wdata_d = result_q[head_q];
    end
  end

  // Walk from head (oldest) towards tail (youngest) so the last match wins.
  // The retiring head is still part of the scan; the incoming result is not.
  always_comb begin
    logic [PTR_W-1:0] idx;
    o_fwd_hit  = 1'b0;
    o_fwd_data = '0;
    idx        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && wen_q[idx] && (rd_q[idx] == i_q_addr)) begin
        o_fwd_hit  = 1'b1;
        o_fwd_data = result_q[idx];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        result_q[i] <= '0;
        rd_q[i]     <= '0;
      end
      wen_q        <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      flag_n_q     <= 1'b0;
      flag_z_q     <= 1'b0;
      last_waddr_q <= '0;
      last_wdata_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        result_q[i] <= result_d[i];
        rd_q[i]     <= rd_d[i];
      end
      wen_q        <= wen_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      flag_n_q     <= flag_n_d;
      flag_z_q     <= flag_z_d;
      last_waddr_q <= last_waddr_d;
      last_wdata_q <= last_wdata_d;
    end
  end

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
- Stage directly downstream of the 16-bit add/sub ALU in the lab CPU datapath.
- Captures each ALU result with its N/Z flags and destination register, maintains the architectural N/Z flag register, and buffers results in a small in-order queue.
- Drains the queue into the register-file write port under a valid/ready handshake.
- Provides a forwarding lookup so the operand stage can bypass buffered, not-yet-written results.

Parameters:
- DATA_W, 16, width of result and register data.
- ADDR_W, 3, register-file address width (8 registers).
- DEPTH, 2, queue entries; power of two, >= 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  upstream ALU result valid.
- o_ready  out  1  stage can accept this cycle.
- i_result  in  DATA_W  ALU output.
- i_n  in  1  ALU negative flag.
- i_z  in  1  ALU zero flag.
- i_rd  in  ADDR_W  destination register.
- i_wr_en  in  1  instruction writes i_rd.
- i_set_flags  in  1  instruction updates N/Z.
- o_rf_we  out  1  register-file write request.
- o_rf_waddr  out  ADDR_W  write address.
- o_rf_wdata  out  DATA_W  write data.
- i_rf_ready  in  1  register file accepts the write this cycle.
- o_flag_n  out  1  architectural N flag.
- o_flag_z  out  1  architectural Z flag.
- i_q_addr  in  ADDR_W  forwarding query register.
- o_fwd_hit  out  1  a buffered entry targets i_q_addr.
- o_fwd_data  out  DATA_W  data of the youngest matching entry.
- o_count  out  clog2(DEPTH)+1  occupancy.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-high.
- Reset (asynchronous, any cycle, including mid-drain) discards all entries.
  - Reset values: count=0, o_rf_we=0, o_fwd_hit=0, o_flag_n=0, o_flag_z=0, o_rf_waddr=0, o_rf_wdata=0, o_fwd_data=0.
- Accept:
  - An upstream transfer occurs when i_valid && o_ready.
  - o_ready = (count < DEPTH). It is registered-state only, with no combinational path from i_rf_ready or i_valid.
  - When full, o_ready=0 even in a cycle where the head retires.
- Queue: circular buffer with wrapping head/tail pointers and an entry format of {result, rd, wr_en}.
  - An entry accepted at edge T is visible at the head at T+1 at the earliest; the latency from accept to o_rf_we is 1 cycle.
- Drain:
  - Head with wr_en=1: o_rf_we=1, o_rf_waddr=head.rd, o_rf_wdata=head.result. It retires on the edge where i_rf_ready=1.
  - While i_rf_ready=0, o_rf_we and its data hold stable.
  - Head with wr_en=0: o_rf_we=0 and it retires unconditionally on the next edge.
  - Empty: o_rf_we=0; o_rf_waddr and o_rf_wdata hold their last values.
- Simultaneous accept and retire: count unchanged, both pointers advance.
  - With count=1, the new entry becomes the head on the following cycle.
- Flags:
  - On accept with i_set_flags=1, flags are updated to {i_n, i_z} at that edge, in program order, independent of drain.
  - i_set_flags=0 leaves the flags unchanged.
  - Flags are never cleared by drain.
- Forwarding (combinational):
  - Scan valid entries with wr_en=1 and rd==i_q_addr.
  - o_fwd_hit=1 if any match; o_fwd_data is the youngest match (nearest tail), else 0.
  - The incoming i_result in the same cycle is NOT included.
  - An entry retiring this cycle is still reported.
- Arithmetic: no modification of data; widths are pass-through. Pointer arithmetic is modulo DEPTH.
- Illegal input: i_valid while o_ready=0 is ignored (no accept, no flag update).

Test Plan:
- Reset, then single transfer {result=0x1234, rd=3, wr_en=1, set_flags=1, n=0, z=0} with i_rf_ready=1 -> next cycle o_rf_we=1, waddr=3, wdata=0x1234; retires; count returns to 0; flags N=0, Z=0.
- Hold i_rf_ready=0 and send 0x0001->r1, then 0xFFFF->r2 -> count=2, o_ready=0, a third i_valid is ignored. Then i_rf_ready=1 -> writes r1, then r2 on consecutive cycles; o_ready rises once count=1.
- Forwarding: buffer 0x00AA->r5 then 0x00BB->r5 with i_rf_ready=0, i_q_addr=5 -> o_fwd_hit=1, o_fwd_data=0x00BB. i_q_addr=4 -> hit=0, data=0.
- Flags: accept result 0x0000 with z=1, set_flags=1, then 0x8000 with n=1, set_flags=0 -> flags N=0, Z=1 after both. An entry with wr_en=0 retires without o_rf_we.
- Simultaneous accept/retire at count=1 over 10 back-to-back transfers -> pointers wrap correctly, write order matches issue order, no drops or duplicates.
- Assert reset mid-stall with count=2 -> outputs immediately take reset values; after release o_ready=1 and no stale writes are issued.
